// File: rtl/sd_emmc_axi_pkg.sv
// sd_emmc_axi_pkg
// Shared definitions for the eMMC DMA AXI memory responder:
//   - AXI response codes (OKAY / SLVERR / DECERR)
//   - write and read FSM state encodings
//   - default largest accepted burst length in beats
package sd_emmc_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int MAX_LEN_DEF = 16;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/sd_emmc_axi_mem_responder_if.sv
// sd_emmc_axi_mem_responder_if
// AXI4 subset (INCR bursts, 32-bit data) between the eMMC DMA master and
// the memory responder.
//   master modport : drives AW/W/AR channels, bready, rready
//   slave  modport : drives awready, wready, B channel, arready, R channel
interface sd_emmc_axi_mem_responder_if;

    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
               araddr, arlen, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
               araddr, arlen, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/sd_emmc_axi_slv_ram.sv
// sd_emmc_axi_slv_ram
// Simple dual-port RAM, 32-bit words, 2^AW deep.
//   clock            : clock
//   we_i/be_i        : write enable and per-byte enables
//   waddr_i/wdata_i  : write word address and data
//   re_i/raddr_i     : read enable and word address
//   rdata_o          : registered read data, updated only when re_i is high
// Read-first: a read and write of the same word in one cycle returns the
// old contents. No reset, so contents survive a system reset.
module sd_emmc_axi_slv_ram #(
    parameter int AW = 10
) (
    input  logic          clock,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [2**AW];
    logic [31:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sd_emmc_axi_mem_responder.sv
// sd_emmc_axi_mem_responder
// AXI4 memory responder modelling system memory behind the eMMC DMA master.
// INCR write and read bursts into a byte-enabled dual-port RAM.
//   clock : system clock
//   reset : synchronous, active-low; both FSMs to idle, RAM kept
//   axi   : slave modport of sd_emmc_axi_mem_responder_if
// Optional build macro SD_AXI_RANGE_CHECK_EN: bursts whose start or end word
// lies outside the memory are flagged (writes dropped, reads return zero,
// response DECERR). Without it the word index wraps modulo the depth.
module sd_emmc_axi_mem_responder
    import sd_emmc_axi_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_LEN   = MAX_LEN_DEF
) (
    input  logic                        clock,
    input  logic                        reset,
    sd_emmc_axi_mem_responder_if.slave  axi
);

    localparam int         IW        = ADDR_W - 2;
    localparam logic [8:0] MAX_BEATS = 9'(MAX_LEN);

    wr_state_e     w_state_q, w_state_d;
    logic [IW-1:0] widx_q, widx_d;
    logic [8:0]    wcnt_q, wcnt_d;
    logic          werr_q, werr_d;
    logic          wdec_q, wdec_d;
    logic [1:0]    bresp_q, bresp_d;

    rd_state_e     r_state_q, r_state_d;
    logic [IW-1:0] ridx_q, ridx_d;
    logic [8:0]    rcnt_q, rcnt_d;
    logic [1:0]    rresp_q, rresp_d;
    logic          rzero_q, rzero_d;

    logic [IW-1:0] aw_idx, ar_idx;
    logic          aw_oor, ar_oor;
    logic          w_final;
    logic          ram_we, ram_re;
    logic [31:0]   ram_rdata;

    // Low two address bits drop out with the shift; the cast wraps modulo depth.
    assign aw_idx = IW'((axi.awaddr - BASE_ADDR) >> 2);
    assign ar_idx = IW'((axi.araddr - BASE_ADDR) >> 2);

`ifdef SD_AXI_RANGE_CHECK_EN
    localparam logic [31:0] DEPTH = 32'(1) << IW;
    logic [31:0] aw_last_word, ar_last_word;
    // Unwrapped end index; start <= end, so checking the end covers both.
    assign aw_last_word = ((axi.awaddr - BASE_ADDR) >> 2) + {24'b0, axi.awlen};
    assign ar_last_word = ((axi.araddr - BASE_ADDR) >> 2) + {24'b0, axi.arlen};
    assign aw_oor = aw_last_word >= DEPTH;
    assign ar_oor = ar_last_word >= DEPTH;
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    // ---------------- write channel ----------------
    assign w_final = (wcnt_q == 9'd1);

    always_comb begin
        w_state_d   = w_state_q;
        widx_d      = widx_q;
        wcnt_d      = wcnt_q;
        werr_d      = werr_q;
        wdec_d      = wdec_q;
        bresp_d     = bresp_q;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        ram_we      = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                // Gated by reset so ready reads low while reset is held.
                axi.awready = reset;
                if (axi.awvalid && reset) begin
                    widx_d    = aw_idx;
                    wcnt_d    = {1'b0, axi.awlen} + 9'd1;
                    werr_d    = ({1'b0, axi.awlen} + 9'd1) > MAX_BEATS;
                    wdec_d    = aw_oor;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                axi.wready = 1'b1;
                if (axi.wvalid) begin
                    ram_we = reset && !werr_q && !wdec_q;
                    widx_d = widx_q + IW'(1);
                    wcnt_d = wcnt_q - 9'd1;
                    // Burst closes on the counted last beat or on wlast,
                    // whichever comes first; any disagreement is SLVERR.
                    if (w_final || axi.wlast) begin
                        if (wdec_q)                              bresp_d = RESP_DECERR;
                        else if (werr_q || (axi.wlast != w_final)) bresp_d = RESP_SLVERR;
                        else                                     bresp_d = RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                axi.bvalid = 1'b1;
                if (axi.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            w_state_q <= W_IDLE;
            widx_q    <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            wdec_q    <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            widx_q    <= widx_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            wdec_q    <= wdec_d;
            bresp_q   <= bresp_d;
        end
    end

    assign axi.bresp = (w_state_q == W_RESP) ? bresp_q : RESP_OKAY;

    // ---------------- read channel ----------------
    // ridx_q always points at the next word to fetch; a fetch is issued in
    // R_FETCH and again on every accepted beat that is not the last, so the
    // RAM output register carries the next beat without a bubble and holds
    // still while the master stalls.
    always_comb begin
        r_state_d   = r_state_q;
        ridx_d      = ridx_q;
        rcnt_d      = rcnt_q;
        rresp_d     = rresp_q;
        rzero_d     = rzero_q;
        axi.arready = 1'b0;
        ram_re      = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                axi.arready = reset;
                if (axi.arvalid && reset) begin
                    ridx_d = ar_idx;
                    rcnt_d = {1'b0, axi.arlen} + 9'd1;
                    if (ar_oor)                                     rresp_d = RESP_DECERR;
                    else if (({1'b0, axi.arlen} + 9'd1) > MAX_BEATS) rresp_d = RESP_SLVERR;
                    else                                            rresp_d = RESP_OKAY;
                    rzero_d   = ar_oor;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                ram_re    = 1'b1;
                ridx_d    = ridx_q + IW'(1);
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (axi.rready) begin
                    rcnt_d = rcnt_q - 9'd1;
                    if (rcnt_q == 9'd1) begin
                        r_state_d = R_IDLE;
                    end else begin
                        ram_re = 1'b1;
                        ridx_d = ridx_q + IW'(1);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state_q <= R_IDLE;
            ridx_q    <= '0;
            rcnt_q    <= '0;
            rresp_q   <= RESP_OKAY;
            rzero_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            ridx_q    <= ridx_d;
            rcnt_q    <= rcnt_d;
            rresp_q   <= rresp_d;
            rzero_q   <= rzero_d;
        end
    end

    assign axi.rvalid = (r_state_q == R_DATA);
    assign axi.rlast  = axi.rvalid && (rcnt_q == 9'd1);
    assign axi.rresp  = axi.rvalid ? rresp_q : RESP_OKAY;
    assign axi.rdata  = (axi.rvalid && !rzero_q) ? ram_rdata : 32'h0;

    sd_emmc_axi_slv_ram #(.AW(IW)) u_ram (
        .clock   (clock),
        .we_i    (ram_we),
        .be_i    (axi.wstrb),
        .waddr_i (widx_q),
        .wdata_i (axi.wdata),
        .re_i    (ram_re),
        .raddr_i (ridx_q),
        .rdata_o (ram_rdata)
    );

endmodule

// File: doc/sd_emmc_axi_mem_responder.md
Name: sd_emmc_axi_mem_responder

Overview:
AXI4 memory-mapped responder (slave) modelling system memory at the far end of the eMMC DMA engine's AXI master port.
- Accepts single- and multi-beat INCR write bursts (card-to-host data) and INCR read bursts (host-to-card data, typically 16 beats / 64 bytes).
- Stores data in an internal byte-enabled dual-port RAM.
- Used in integration benches and as an on-chip bounce buffer.

Parameters:
ADDR_W, 12, byte-address bits decoded; memory depth = 2^(ADDR_W-2) 32-bit words
BASE_ADDR, 32'h0000_0000, system address mapped to memory word 0
MAX_LEN, 16, largest accepted burst length in beats (AxLEN+1)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low
awaddr  input  32  write burst start byte address
awlen  input  8  write beats minus one
awvalid  input  1  write address valid
awready  output  1  write address ready
wdata  input  32  write data
wstrb  input  4  byte strobes
wlast  input  1  last write beat
wvalid  input  1  write data valid
wready  output  1  write data ready
bresp  output  2  write response
bvalid  output  1  write response valid
bready  input  1  write response ready
araddr  input  32  read burst start byte address
arlen  input  8  read beats minus one
arvalid  input  1  read address valid
arready  output  1  read address ready
rdata  output  32  read data
rresp  output  2  read response
rlast  output  1  last read beat
rvalid  output  1  read data valid
rready  input  1  read data ready

Behaviour:
- Reset (reset==0 at a clock edge): all outputs 0, both FSMs to idle, any in-flight burst abandoned. RAM contents preserved.
- Bursts: INCR only; word index = ((addr-BASE_ADDR)>>2) mod 2^(ADDR_W-2); low two address bits ignored.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On awvalid&awready: latch word index, beat count = awlen+1, error flag = (awlen+1 > MAX_LEN); go W_DATA.
  - W_DATA: wready=1. Each wvalid&wready writes the word with wstrb byte enables, index+1, count-1.
  - Over-length burst: beats are accepted but not stored.
  - Burst end on final counted beat or wlast. Go W_RESP with bvalid=1 next cycle.
  - Errors: bresp=2'b10 (SLVERR) if wlast early, wlast missing on final beat, or over-length; else 2'b00.
  - W_RESP: bvalid held until bready; then W_IDLE. awready low throughout W_DATA and W_RESP.
- Read FSM R_IDLE -> R_FETCH -> R_DATA:
  - R_IDLE: arready=1. On handshake, latch index and count; go R_FETCH (RAM latency 1).
  - R_FETCH: issue RAM read; next cycle rvalid=1 with data in R_DATA.
  - R_DATA: rdata, rlast, rresp stable while rvalid&!rready.
  - On rvalid&rready: advance index. If beats remain, the next word is presented back-to-back (prefetched) with no bubble cycle.
  - rlast=1 exactly on beat arlen. rresp=2'b10 on every beat of an over-length burst, else 2'b00.
  - After the last beat, return to R_IDLE; arready is reasserted the following cycle.
- Write and read channels run concurrently. A same-word write and read in one cycle returns the old data (read-first).
- Wrap: the index wraps from the top word to word 0 silently, unless SD_AXI_RANGE_CHECK_EN is defined.
- Latency: first rdata 2 cycles after the ar handshake; bvalid 1 cycle after the last w beat.

Optional Feature:
SD_AXI_RANGE_CHECK_EN.
- Defined: any burst whose start or end word index exceeds the memory depth is flagged.
  - Writes to a flagged burst are suppressed; bresp=2'b11 (DECERR).
  - Reads of a flagged burst return rdata=0 with rresp=2'b11 on all beats.
- Undefined: no check; the address wraps modulo depth.

Decomposition:
Package sd_emmc_axi_pkg:
- RESP_OKAY/SLVERR/DECERR codes
- write/read FSM state encodings
- MAX_LEN default

Sub-module sd_emmc_axi_slv_ram: simple dual-port RAM with one write port (4-bit byte enable) and one registered read port, read-first.

Test Plan:
1. Single write awaddr=0x100, awlen=0, wdata=0xA5A5_1234, wstrb=4'hF, bready=1 -> bvalid 1 cycle after the w beat, bresp=00; later a read of 0x100 returns 0xA5A5_1234 with rlast=1.
2. 16-beat read araddr=0x40, arlen=15, rready=1 continuously -> 16 back-to-back beats, first beat 2 cycles after arready; rlast only on beat 16; data matches preloaded words 16..31.
3. Read with rready toggled 1,0,0,1,... -> rdata/rlast held stable while stalled; no beat lost or duplicated.
4. Write awlen=3 with wlast asserted on beat 2 -> burst closes after beat 2, bresp=10; words 0-1 written, words 2-3 unchanged.
5. Partial strobe: prior 0xFFFF_FFFF, write 0x1122_3344 with wstrb=4'b0101 -> read returns 0xFF22_FF44.
6. Reset asserted mid-read at beat 5 of 16 -> next cycle rvalid=0, arready=0 during reset, arready=1 after release; a new read returns correct data.
